// File: rtl/uart8_rx_buffer_pkg.sv
// Common types and helpers for the UART receive buffer.
`include "UartBuffer.vh"

package uart8_rx_buffer_pkg;
  localparam int DATA_W   = `UART_DATA_W;
  localparam int ERRCNT_W = `UART_ERRCNT_W;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

  function automatic logic [ERRCNT_W-1:0] satInc(input logic [ERRCNT_W-1:0] v);
    return (v == ERRCNT_MAX) ? v : v + ERRCNT_W'(1);
  endfunction
endpackage

// File: rtl/UartBuffer.vh
// Shared widths for the UART receive path.
`ifndef UART_BUFFER_VH
`define UART_BUFFER_VH
`define UART_DATA_W 8
`define UART_ERRCNT_W 8
`endif

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word fall-through byte FIFO with wrap-bit pointers.
module uart_byte_fifo
  import uart8_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     pushData,
  input  logic                  pop,
  output logic [DATA_W-1:0]     popData,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wrPtr;
  logic [DEPTH_LOG2:0] rdPtr;
  logic                wrAccept;
  logic                rdAccept;

  // A push at full is still taken when the head leaves in the same cycle.
  assign wrAccept = push && (!full || pop);
  assign rdAccept = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (rdAccept) rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr[DEPTH_LOG2-1:0]] <= pushData;
  end

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]) &&
                   (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]);
  assign count   = wrPtr - rdPtr;
  assign popData = empty ? '0 : mem[rdPtr[DEPTH_LOG2-1:0]];
endmodule

// File: rtl/uart8_rx_buffer.sv
// Buffers UART receiver done/err/out pulses into a valid/ready byte stream with status.
module uart8_rx_buffer
  import uart8_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxDone,
  input  logic                  rxErr,
  input  logic [DATA_W-1:0]     rxData,
  output logic [DATA_W-1:0]     dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  output logic [ERRCNT_W-1:0]   errCount,
  input  logic                  clearStatus
);
  logic doneQ;
  logic errQ;
  logic push;
  logic pop;
  logic errEdge;
  logic overflowEvent;
  logic empty;

  // Edge registers reset high so a level already asserted at release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      doneQ <= 1'b1;
      errQ  <= 1'b1;
    end else begin
      doneQ <= rxDone;
      errQ  <= rxErr;
    end
  end

  assign push          = rxDone && !doneQ;
  assign errEdge       = rxErr && !errQ;
  assign pop           = dataValid && dataReady;
  assign overflowEvent = push && full && !pop;
  assign dataValid     = !empty;

  uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (rxData),
    .pop      (pop),
    .popData  (dataOut),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // A status event in the same cycle as clearStatus takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      errCount <= '0;
    end else begin
      if (overflowEvent)    overflow <= 1'b1;
      else if (clearStatus) overflow <= 1'b0;

      if (errEdge)          errCount <= clearStatus ? ERRCNT_W'(1) : satInc(errCount);
      else if (clearStatus) errCount <= '0;
    end
  end
endmodule
